spinner_multi: RTL and testbench



---
 rtl/spinner_pkg.sv | 28 ++
 rtl/spinner_chan.sv | 122 ++++++++++++
 rtl/spinner_multi.sv | 67 ++++++
 tb/tb_spinner_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
// Shared types and helpers for the multi-channel spinner/paddle generator.
package spinner_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_PLUS  = 2'd1,
    DIR_MINUS = 2'd2
  } dir_e;

  localparam int ACC_W  = 12;
  localparam int HOLD_W = 8;
  localparam int DX_W   = 9;

  // Symmetric accumulator limit (+/-2047); -2048 is never produced.
  localparam logic signed [ACC_W:0] ACC_SAT = (ACC_W + 1)'((1 << (ACC_W - 1)) - 1);

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [DX_W-1:0]  b
  );
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W + 1 - DX_W){b[DX_W-1]}}, b});
    if (s > ACC_SAT) s = ACC_SAT;
    else if (s < -ACC_SAT) s = -ACC_SAT;
    return s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: hold-time acceleration, wrap/clamp angle update, change strobe.
// The mouse accumulator is only built when SPINNER_MOUSE_EN is defined.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int INIT_ANGLE   = 0,
  parameter int MOUSE_SHIFT  = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tick_i,
  input  logic                   plus_i,
  input  logic                   minus_i,
  input  logic                   fast_i,
  input  logic                   enable_i,
  input  logic                   paddle_i,
  input  logic                   mouse_add_i,
  input  logic signed [DX_W-1:0] mouse_dx_i,
  output logic [WIDTH-1:0]       angle_o,
  output logic                   moved_o
);

  // Wide enough for angle + step + full mouse quotient without overflow.
  localparam int SUM_W = ((WIDTH > ACC_W) ? WIDTH : ACC_W) + 2;
  localparam logic [HOLD_W-1:0]       ACCEL_H   = HOLD_W'(ACCEL_FRAMES);
  localparam logic signed [SUM_W-1:0] SLOW_S    = SUM_W'(STEP_SLOW);
  localparam logic signed [SUM_W-1:0] FAST_S    = SUM_W'(STEP_FAST);
  localparam logic signed [SUM_W-1:0] ANGLE_MAX = SUM_W'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0]        INIT_A    = WIDTH'(INIT_ANGLE);

  function automatic logic [WIDTH-1:0] fold_angle(
    input logic signed [SUM_W-1:0] s,
    input logic                    clamp
  );
    logic [WIDTH-1:0] r;
    r = s[WIDTH-1:0];
    if (clamp && s[SUM_W-1]) r = '0;
    else if (clamp && (s > ANGLE_MAX)) r = '1;
    return r;
  endfunction

  dir_e                    dir_now, dir_q, dir_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [WIDTH-1:0]        angle_q, angle_d;
  logic                    moved_q, moved_d;
  logic signed [SUM_W-1:0] step_s, dig_s, q_s, sum_s;

  always_comb begin
    if (plus_i && !minus_i) dir_now = DIR_PLUS;
    else if (minus_i && !plus_i) dir_now = DIR_MINUS;
    else dir_now = DIR_NONE;
  end

`ifdef SPINNER_MOUSE_EN
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_int, acc_res, acc_base;

  // A tick consumes whole units; a same-cycle dx lands on the leftover residue.
  always_comb begin
    acc_int  = acc_q >>> MOUSE_SHIFT;
    acc_res  = acc_q - (acc_int <<< MOUSE_SHIFT);
    q_s      = $signed({{(SUM_W - ACC_W){acc_int[ACC_W-1]}}, acc_int});
    acc_base = tick_i ? acc_res : acc_q;
    acc_d    = mouse_add_i ? sat_add(acc_base, mouse_dx_i) : acc_base;
    if (!enable_i) acc_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) acc_q <= '0;
    else acc_q <= acc_d;
  end
`else
  logic unused_mouse;
  assign unused_mouse = ^{mouse_add_i, mouse_dx_i};
  assign q_s = '0;
`endif

  always_comb begin
    dir_d   = dir_q;
    hold_d  = hold_q;
    angle_d = angle_q;
    moved_d = 1'b0;
    step_s  = SLOW_S;
    dig_s   = '0;
    sum_s   = '0;
    if (!enable_i) begin
      dir_d  = DIR_NONE;
      hold_d = '0;
    end else if (tick_i) begin
      dir_d = dir_now;
      if (dir_now == DIR_NONE || dir_now != dir_q) hold_d = '0;
      else if (hold_q < ACCEL_H) hold_d = hold_q + HOLD_W'(1);
      step_s = (fast_i || hold_d == ACCEL_H) ? FAST_S : SLOW_S;
      if (dir_now == DIR_PLUS) dig_s = step_s;
      else if (dir_now == DIR_MINUS) dig_s = -step_s;
      sum_s   = $signed({{(SUM_W - WIDTH){1'b0}}, angle_q}) + dig_s + q_s;
      angle_d = fold_angle(sum_s, paddle_i);
      moved_d = (angle_d != angle_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dir_q   <= DIR_NONE;
      hold_q  <= '0;
      angle_q <= INIT_A;
      moved_q <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      angle_q <= angle_d;
      moved_q <= moved_d;
    end
  end

  assign angle_o = angle_q;
  assign moved_o = moved_q;

endmodule

// File: rtl/spinner_multi.sv
// Multi-channel spinner/paddle angle generator, updated once per frame tick.
// Define SPINNER_MOUSE_EN to route mouse_dx into the selected channel's accumulator.
module spinner_multi
  import spinner_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 8,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int INIT_ANGLE   = 0,
  parameter int MOUSE_SHIFT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [CHANNELS-1:0]       fast,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       paddle_mode,
  input  logic signed [DX_W-1:0]    mouse_dx,
  input  logic                      mouse_strobe,
  input  logic [1:0]                mouse_sel,
  output logic [CHANNELS*WIDTH-1:0] angle,
  output logic [CHANNELS-1:0]       moved
);

  logic strobe_q;
  logic tick;

  always_ff @(posedge clk) begin
    if (reset) strobe_q <= 1'b0;
    else strobe_q <= strobe;
  end

  assign tick = strobe & ~strobe_q;

  // A mouse_sel beyond the last channel matches nothing and is dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic hit;
    assign hit = mouse_strobe && (mouse_sel == 2'(i));

    spinner_chan #(
      .WIDTH       (WIDTH),
      .STEP_SLOW   (STEP_SLOW),
      .STEP_FAST   (STEP_FAST),
      .ACCEL_FRAMES(ACCEL_FRAMES),
      .INIT_ANGLE  (INIT_ANGLE),
      .MOUSE_SHIFT (MOUSE_SHIFT)
    ) u_chan (
      .clk_i      (clk),
      .reset_i    (reset),
      .tick_i     (tick),
      .plus_i     (plus[i]),
      .minus_i    (minus[i]),
      .fast_i     (fast[i]),
      .enable_i   (enable[i]),
      .paddle_i   (paddle_mode[i]),
      .mouse_add_i(hit),
      .mouse_dx_i (mouse_dx),
      .angle_o    (angle[i*WIDTH +: WIDTH]),
      .moved_o    (moved[i])
    );
  end

endmodule

// File: tb/tb_spinner_multi.sv
// Directed self-checking bench for spinner_multi (2 channels, 8-bit angle, default steps).
module tb_spinner_multi;
  localparam int CH = 2;
  localparam int W  = 8;

  logic                clk = 1'b0;
  logic                reset, strobe;
  logic [CH-1:0]       plus, minus, fast, enable, paddle_mode;
  logic signed [8:0]   mouse_dx;
  logic                mouse_strobe;
  logic [1:0]          mouse_sel;
  logic [CH*W-1:0]     angle;
  logic [CH-1:0]       moved;
  int checks = 0;
  int errors = 0;

  spinner_multi #(
    .CHANNELS(CH), .WIDTH(W), .STEP_SLOW(1), .STEP_FAST(4),
    .ACCEL_FRAMES(8), .INIT_ANGLE(0), .MOUSE_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .plus(plus), .minus(minus),
    .fast(fast), .enable(enable), .paddle_mode(paddle_mode), .mouse_dx(mouse_dx),
    .mouse_strobe(mouse_strobe), .mouse_sel(mouse_sel), .angle(angle), .moved(moved)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ang(input int ch);
    return angle[ch*W +: W];
  endfunction

  task automatic do_reset();
    reset = 1'b1; strobe = 1'b0; plus = '0; minus = '0; fast = '0;
    enable = '1; paddle_mode = '0; mouse_dx = '0; mouse_strobe = 1'b0; mouse_sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the updated angle stable.
  task automatic pulse_tick(output logic [CH-1:0] mv);
    strobe = 1'b1;
    @(negedge clk);
    mv = moved;
    strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic mouse_in(input logic [1:0] sel, input logic signed [8:0] dx);
    mouse_sel = sel; mouse_dx = dx; mouse_strobe = 1'b1;
    @(negedge clk);
    mouse_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ang(0) !== 8'd0) begin errors++; $display("FAIL reset_ch0: angle=%0d expected 0", ang(0)); end
    checks++; if (ang(1) !== 8'd0) begin errors++; $display("FAIL reset_ch1: angle=%0d expected 0", ang(1)); end
    checks++; if (moved !== 2'b00) begin errors++; $display("FAIL reset_moved: moved=%b expected 00", moved); end
  endtask

  task automatic test_accel();
    logic [CH-1:0] mv;
    int exp_a [10];
    exp_a = '{1, 2, 3, 4, 5, 6, 7, 8, 12, 16};
    do_reset();
    plus[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_tick(mv);
      checks++; if (ang(0) !== W'(exp_a[i])) begin errors++; $display("FAIL accel_angle tick%0d: angle=%0d expected %0d", i + 1, ang(0), exp_a[i]); end
      checks++; if (mv !== 2'b01) begin errors++; $display("FAIL accel_moved tick%0d: moved=%b expected 01", i + 1, mv); end
    end
    checks++; if (moved !== 2'b00) begin errors++; $display("FAIL moved_width: moved=%b expected 00", moved); end
    checks++; if (ang(1) !== 8'd0) begin errors++; $display("FAIL accel_ch1_idle: angle=%0d expected 0", ang(1)); end
    plus[0] = 1'b0;
  endtask

  task automatic test_wrap_clamp();
    logic [CH-1:0] mv;
    do_reset();
    minus[0] = 1'b1;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd255) begin errors++; $display("FAIL wrap_under: angle=%0d expected 255", ang(0)); end
    pulse_tick(mv);
    minus[0] = 1'b0; plus[0] = 1'b1; fast[0] = 1'b1;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd2) begin errors++; $display("FAIL wrap_over: angle=%0d expected 2", ang(0)); end
    checks++; if (mv[0] !== 1'b1) begin errors++; $display("FAIL wrap_moved: moved=%b expected 1", mv[0]); end

    do_reset();
    minus[0] = 1'b1;
    pulse_tick(mv);
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd254) begin errors++; $display("FAIL clamp_setup: angle=%0d expected 254", ang(0)); end
    minus[0] = 1'b0; paddle_mode[0] = 1'b1; plus[0] = 1'b1; fast[0] = 1'b1;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd255) begin errors++; $display("FAIL clamp_hi: angle=%0d expected 255", ang(0)); end
    checks++; if (mv[0] !== 1'b1) begin errors++; $display("FAIL clamp_hi_moved: moved=%b expected 1", mv[0]); end
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd255) begin errors++; $display("FAIL clamp_hold: angle=%0d expected 255", ang(0)); end
    checks++; if (mv[0] !== 1'b0) begin errors++; $display("FAIL clamp_nopulse: moved=%b expected 0", mv[0]); end

    do_reset();
    paddle_mode[0] = 1'b1; minus[0] = 1'b1;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd0) begin errors++; $display("FAIL clamp_lo: angle=%0d expected 0", ang(0)); end
    checks++; if (mv[0] !== 1'b0) begin errors++; $display("FAIL clamp_lo_moved: moved=%b expected 0", mv[0]); end
    minus[0] = 1'b0; paddle_mode[0] = 1'b0;
  endtask

  task automatic test_reversal();
    logic [CH-1:0] mv;
    do_reset();
    plus[0] = 1'b1;
    repeat (9) pulse_tick(mv);
    checks++; if (ang(0) !== 8'd12) begin errors++; $display("FAIL rev_accel: angle=%0d expected 12", ang(0)); end
    plus[0] = 1'b0; minus[0] = 1'b1;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd11) begin errors++; $display("FAIL rev_slow: angle=%0d expected 11", ang(0)); end
    plus[0] = 1'b1;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd11) begin errors++; $display("FAIL rev_both: angle=%0d expected 11", ang(0)); end
    checks++; if (mv[0] !== 1'b0) begin errors++; $display("FAIL rev_both_moved: moved=%b expected 0", mv[0]); end
    minus[0] = 1'b0;
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd12) begin errors++; $display("FAIL rev_after_both: angle=%0d expected 12", ang(0)); end
    plus[0] = 1'b0;
  endtask

  task automatic test_mouse();
    logic [CH-1:0] mv;
    do_reset();
`ifdef SPINNER_MOUSE_EN
    mouse_in(2'd1, 9'sd7);
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd1) begin errors++; $display("FAIL mouse_p7: angle=%0d expected 1", ang(1)); end
    checks++; if (mv !== 2'b10) begin errors++; $display("FAIL mouse_p7_moved: moved=%b expected 10", mv); end
    mouse_in(2'd1, 9'sd1);
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd2) begin errors++; $display("FAIL mouse_residue: angle=%0d expected 2", ang(1)); end
    mouse_in(2'd1, -9'sd5);
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd0) begin errors++; $display("FAIL mouse_floor: angle=%0d expected 0", ang(1)); end
    // residue now 3; dx=+4 arriving on the tick edge must wait for the next tick
    mouse_sel = 2'd1; mouse_dx = 9'sd4; mouse_strobe = 1'b1; strobe = 1'b1;
    @(negedge clk);
    mv = moved; mouse_strobe = 1'b0; strobe = 1'b0;
    @(negedge clk);
    checks++; if (ang(1) !== 8'd0 || mv[1] !== 1'b0) begin errors++; $display("FAIL mouse_coincident: angle=%0d moved=%b expected 0/0", ang(1), mv[1]); end
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd1) begin errors++; $display("FAIL mouse_deferred: angle=%0d expected 1", ang(1)); end
    mouse_in(2'd2, 9'sd40);
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd0 || ang(1) !== 8'd1) begin errors++; $display("FAIL mouse_sel_range: angles=%0d,%0d expected 0,1", ang(0), ang(1)); end
    mouse_in(2'd0, -9'sd4);
    pulse_tick(mv);
    checks++; if (ang(0) !== 8'd255) begin errors++; $display("FAIL mouse_ch0: angle=%0d expected 255", ang(0)); end
    enable[1] = 1'b0;
    mouse_in(2'd1, 9'sd40);
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd1 || mv[1] !== 1'b0) begin errors++; $display("FAIL mouse_disabled: angle=%0d moved=%b expected 1/0", ang(1), mv[1]); end
    enable[1] = 1'b1;
    mouse_in(2'd1, 9'sd1);
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd1) begin errors++; $display("FAIL mouse_acc_cleared: angle=%0d expected 1", ang(1)); end
`else
    mouse_in(2'd1, 9'sd40);
    pulse_tick(mv);
    checks++; if (ang(1) !== 8'd0 || mv !== 2'b00) begin errors++; $display("FAIL mouse_ignored: angle=%0d moved=%b expected 0/00", ang(1), mv); end
`endif
  endtask

  task automatic test_strobe_hold();
    int cnt;
    do_reset();
    plus[0] = 1'b1; cnt = 0; strobe = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (moved[0]) cnt++;
    end
    strobe = 1'b0;
    @(negedge clk);
    checks++; if (cnt !== 1) begin errors++; $display("FAIL strobe_hold_pulses: count=%0d expected 1", cnt); end
    checks++; if (ang(0) !== 8'd1) begin errors++; $display("FAIL strobe_hold_angle: angle=%0d expected 1", ang(0)); end
    plus[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [CH-1:0] mv;
    do_reset();
    plus[0] = 1'b1;
    repeat (3) pulse_tick(mv);
    checks++; if (ang(0) !== 8'd3) begin errors++; $display("FAIL midreset_setup: angle=%0d expected 3", ang(0)); end
    reset = 1'b1; strobe = 1'b1;
    @(negedge clk);
    checks++; if (ang(0) !== 8'd0 || moved !== 2'b00) begin errors++; $display("FAIL midreset: angle=%0d moved=%b expected 0/00", ang(0), moved); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ang(0) !== 8'd1 || moved !== 2'b01) begin errors++; $display("FAIL strobe_out_of_reset: angle=%0d moved=%b expected 1/01", ang(0), moved); end
    strobe = 1'b0; plus[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_accel();
    test_wrap_clamp();
    test_reversal();
    test_mouse();
    test_strobe_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
